// File: rtl/x_in_to_n_out_pkg.sv
`default_nettype none
// ============================================================================
// Module   : x_in_to_n_out_pkg
// Brief    : Shared sizing helpers for the x_in_to_n_out serialiser.
// Revision : 1.0 - initial release
// ============================================================================
package x_in_to_n_out_pkg;

  function automatic int num_slices(input int num_ins, input int num_outs);
    return (num_ins + num_outs - 1) / num_outs;
  endfunction

  function automatic int cnt_width(input int n_slices);
    return (n_slices <= 1) ? 1 : $clog2(n_slices);
  endfunction

endpackage
`default_nettype wire

// File: rtl/x_in_to_n_out_wrap_cnt.sv
`default_nettype none
// ============================================================================
// Module   : wrap_cnt
// Brief    : Enable-gated counter wrapping from MAX-1 back to 0.
// Revision : 1.0 - initial release
// ============================================================================
module wrap_cnt
  import x_in_to_n_out_pkg::*;
#(
  parameter int MAX = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  output logic [cnt_width(MAX)-1:0]   cnt,
  output logic                        last
);

  localparam int            W      = cnt_width(MAX);
  localparam logic [W-1:0]  c_LAST = W'(MAX - 1);

  logic [W-1:0] r_cnt;

  assign last = (r_cnt == c_LAST);
  assign cnt  = r_cnt;

  // Explicit compare-to-last keeps non-power-of-two ranges from overrunning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= last ? '0 : r_cnt + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/x_in_to_n_out.sv
`default_nettype none
// ============================================================================
// Module   : x_in_to_n_out
// Brief    : Captures an input vector once per frame and streams it out
//            NUM_OUTS bits per cycle, LSB slice first, with a frame flag.
//            Optional frame parity enabled by X_IN_TO_N_OUT_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module x_in_to_n_out
  import x_in_to_n_out_pkg::*;
#(
  parameter int NUM_INS  = 8,
  parameter int NUM_OUTS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_INS-1:0]  in,
  input  logic                hold,
  output logic [NUM_OUTS-1:0] out,
  output logic                sof
`ifdef X_IN_TO_N_OUT_PARITY_EN
  ,
  output logic                par
`endif
);

  localparam int NUM_SLICES = num_slices(NUM_INS, NUM_OUTS);
  localparam int CNT_W      = cnt_width(NUM_SLICES);
  localparam int PAD_W      = NUM_SLICES * NUM_OUTS;

  logic                                 w_en;
  logic                                 w_last;
  logic [CNT_W-1:0]                     w_cnt;
  logic                                 w_first;
  logic [PAD_W-1:0]                     w_padded;
  logic [NUM_OUTS-1:0]                  w_slice;
  logic [NUM_SLICES-1:0][NUM_OUTS-1:0]  r_snap;
  logic [NUM_OUTS-1:0]                  r_out;
  logic                                 r_sof;

  assign w_en    = ~hold;
  assign w_first = (w_cnt == '0);

  wrap_cnt #(
    .MAX (NUM_SLICES)
  ) u_wrap_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en),
    .cnt  (w_cnt),
    .last (w_last)
  );

  always_comb begin
    w_padded               = '0;
    w_padded[NUM_INS-1:0]  = in;
  end

  // Slice 0 bypasses the snapshot so it leaves in the same cycle it is sampled.
  assign w_slice = w_first ? w_padded[NUM_OUTS-1:0] : r_snap[w_cnt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= '0;
      r_out  <= '0;
      r_sof  <= 1'b0;
    end else if (w_en) begin
      if (w_first) begin
        r_snap <= w_padded;
      end
      r_out <= w_slice;
      r_sof <= w_first;
    end
  end

  assign out = r_out;
  assign sof = r_sof;

`ifdef X_IN_TO_N_OUT_PARITY_EN
  logic [NUM_OUTS-1:0] r_acc;
  logic                r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_par <= 1'b0;
    end else if (w_en) begin
      if (w_last) begin
        r_par <= ^(r_acc ^ w_slice);
        r_acc <= '0;
      end else begin
        r_acc <= r_acc ^ w_slice;
      end
    end
  end

  assign par = r_par;
`else
  logic w_unused_last;
  assign w_unused_last = w_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_x_in_to_n_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_x_in_to_n_out
// Brief    : Scoreboard bench driving four differently sized serialisers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_x_in_to_n_out;

  localparam int ND = 4;
  localparam int NI [ND] = '{8, 10, 8, 5};
  localparam int NO [ND] = '{1, 4, 2, 8};

  typedef struct {
    int          d;
    logic [31:0] out;
    logic        sof;
    logic        par;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        hold;
  logic [31:0] v_in [ND];

  logic [7:0]  in0;
  logic [9:0]  in1;
  logic [7:0]  in2;
  logic [4:0]  in3;
  logic [0:0]  out0;
  logic [3:0]  out1;
  logic [1:0]  out2;
  logic [7:0]  out3;
  logic        sof_w [ND];
  logic        par_w [ND];
  logic [31:0] out_w [ND];

  assign in0 = v_in[0][7:0];
  assign in1 = v_in[1][9:0];
  assign in2 = v_in[2][7:0];
  assign in3 = v_in[3][4:0];
  assign out_w[0] = {31'd0, out0};
  assign out_w[1] = {28'd0, out1};
  assign out_w[2] = {30'd0, out2};
  assign out_w[3] = {24'd0, out3};

`ifdef X_IN_TO_N_OUT_PARITY_EN
  x_in_to_n_out #(.NUM_INS(8),  .NUM_OUTS(1)) u_d0 (.clk(clk), .rst(rst), .in(in0), .hold(hold),
    .out(out0), .sof(sof_w[0]), .par(par_w[0]));
  x_in_to_n_out #(.NUM_INS(10), .NUM_OUTS(4)) u_d1 (.clk(clk), .rst(rst), .in(in1), .hold(hold),
    .out(out1), .sof(sof_w[1]), .par(par_w[1]));
  x_in_to_n_out #(.NUM_INS(8),  .NUM_OUTS(2)) u_d2 (.clk(clk), .rst(rst), .in(in2), .hold(hold),
    .out(out2), .sof(sof_w[2]), .par(par_w[2]));
  x_in_to_n_out #(.NUM_INS(5),  .NUM_OUTS(8)) u_d3 (.clk(clk), .rst(rst), .in(in3), .hold(hold),
    .out(out3), .sof(sof_w[3]), .par(par_w[3]));
`else
  x_in_to_n_out #(.NUM_INS(8),  .NUM_OUTS(1)) u_d0 (.clk(clk), .rst(rst), .in(in0), .hold(hold),
    .out(out0), .sof(sof_w[0]));
  x_in_to_n_out #(.NUM_INS(10), .NUM_OUTS(4)) u_d1 (.clk(clk), .rst(rst), .in(in1), .hold(hold),
    .out(out1), .sof(sof_w[1]));
  x_in_to_n_out #(.NUM_INS(8),  .NUM_OUTS(2)) u_d2 (.clk(clk), .rst(rst), .in(in2), .hold(hold),
    .out(out2), .sof(sof_w[2]));
  x_in_to_n_out #(.NUM_INS(5),  .NUM_OUTS(8)) u_d3 (.clk(clk), .rst(rst), .in(in3), .hold(hold),
    .out(out3), .sof(sof_w[3]));
  initial for (int i = 0; i < ND; i++) par_w[i] = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb [$];

  // Reference model: frame vector, slice index and the outputs it implies.
  int          m_k   [ND];
  logic [31:0] m_vec [ND];
  logic [31:0] m_out [ND];
  logic        m_sof [ND];
  logic        m_par [ND];

  function automatic int nslices(input int d);
    return (NI[d] + NO[d] - 1) / NO[d];
  endfunction

  function automatic logic [31:0] lmask(input int bits);
    return (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
  endfunction

  task automatic check(input string name, input int d, input logic [33:0] got,
                       input logic [33:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got out/sof/par=%h expected %h at %0t", name, d, got, exp,
               $time);
    end
  endtask

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
`ifdef X_IN_TO_N_OUT_PARITY_EN
      check("stream", e.d, {out_w[e.d], sof_w[e.d], par_w[e.d]}, {e.out, e.sof, e.par});
`else
      check("stream", e.d, {out_w[e.d], sof_w[e.d], 1'b0}, {e.out, e.sof, 1'b0});
`endif
    end
  end

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_k[d] = 0; m_vec[d] = '0; m_out[d] = '0; m_sof[d] = 1'b0; m_par[d] = 1'b0;
    end
  endtask

  // Called at a falling edge: apply inputs, predict the next rising edge, push.
  task automatic step(input logic hv);
    hold = hv;
    for (int d = 0; d < ND; d++) begin
      if (!hv) begin
        if (m_k[d] == 0) m_vec[d] = v_in[d] & lmask(NI[d]);
        m_out[d] = (m_vec[d] >> (m_k[d] * NO[d])) & lmask(NO[d]);
        m_sof[d] = (m_k[d] == 0);
        if (m_k[d] == nslices(d) - 1) m_par[d] = ^m_vec[d];
        m_k[d] = (m_k[d] + 1) % nslices(d);
      end
      sb.push_back('{d: d, out: m_out[d], sof: m_sof[d], par: m_par[d]});
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < ND; d++)
      check("async_reset", d, {out_w[d], sof_w[d], par_w[d]}, 34'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    clk  = 1'b0;
    rst  = 1'b1;
    hold = 1'b0;
    for (int d = 0; d < ND; d++) v_in[d] = '0;
    model_reset();
    @(negedge clk);
    for (int d = 0; d < ND; d++)
      check("reset_state", d, {out_w[d], sof_w[d], par_w[d]}, 34'd0);
    rst = 1'b0;

    // Directed frames: A5 bit-serial, 3FF in 4-bit slices, 1B then FF in 2-bit slices.
    v_in[0] = 32'hA5; v_in[1] = 32'h3FF; v_in[2] = 32'h1B; v_in[3] = 32'h15;
    step(1'b0);
    v_in[2] = 32'hFF; v_in[3] = 32'h0A;
    for (int i = 0; i < 23; i++) step(1'b0);

    // Parity frames: 07 then 03 on the 2-bit lane.
    v_in[2] = 32'h07;
    for (int i = 0; i < 4; i++) step(1'b0);
    v_in[2] = 32'h03;
    for (int i = 0; i < 4; i++) step(1'b0);

    // Freeze mid-frame with inputs changing underneath.
    step(1'b0); step(1'b0); step(1'b0);
    for (int i = 0; i < 5; i++) begin
      for (int d = 0; d < ND; d++) v_in[d] = $urandom;
      step(1'b1);
    end
    for (int i = 0; i < 6; i++) step(1'b0);

    // Reset mid-frame while hold is also asserted.
    step(1'b0); step(1'b0);
    hold = 1'b1;
    reset_pulse();
    for (int i = 0; i < 10; i++) step(1'b0);

    for (int i = 0; i < 300; i++) begin
      for (int d = 0; d < ND; d++) v_in[d] = $urandom;
      if (i == 150) reset_pulse();
      step($urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/x_in_to_n_out.md
X_IN_TO_N_OUT -- requirements
Module: x_in_to_n_out

Interface
REQ-001 Parameter NUM_INS, default 8: width of input vector under test; SHALL be >= 1.
REQ-002 Parameter NUM_OUTS, default 1: number of output lanes; SHALL be >= 1.
REQ-003 Port clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in  input  NUM_INS  vector to be serialised.
REQ-006 Port hold  input  1  freeze; when high, all state SHALL keep its value.
REQ-007 Port out  output  NUM_OUTS  current slice of the captured vector, registered.
REQ-008 Port sof  output  1  registered start-of-frame flag, high while out carries slice 0.

Function
REQ-009 NUM_SLICES SHALL equal ceil(NUM_INS/NUM_OUTS); in SHALL be zero-padded at the MSB end to NUM_SLICES*NUM_OUTS bits.
REQ-010 Slice counter cnt: width max(1, clog2(NUM_SLICES)); SHALL increment by 1 each cycle hold is low.
REQ-011 cnt SHALL wrap from NUM_SLICES-1 to 0, including non-power-of-two NUM_SLICES; cnt SHALL never index past the last slice.
REQ-012 On a cycle with hold low and cnt==0, the snapshot register snap SHALL load padded in; out SHALL load slice 0 of padded in directly; sof SHALL load 1.
REQ-013 On a cycle with hold low and cnt==k, k!=0: out SHALL load snap bits [k*NUM_OUTS +: NUM_OUTS]; sof SHALL load 0; snap SHALL be unchanged.
REQ-014 Latency: slice k of a vector sampled at cycle t SHALL appear on out at the end of cycle t+k; all slices of one frame SHALL come from the same sample.
REQ-015 hold high SHALL freeze cnt, snap, out and sof (and par when compiled in); no slice is skipped or repeated on release.
REQ-016 NUM_SLICES==1: cnt SHALL stay 0, out SHALL be padded in delayed by one cycle, sof SHALL be constant 1 after the first enabled cycle.
REQ-017 Changes of in on cycles with cnt!=0 SHALL NOT affect the current frame.

Reset
REQ-018 rst high SHALL asynchronously force cnt=0, snap=0, out=0, sof=0 (and par=0, acc=0 when compiled in).
REQ-019 rst asserted mid-frame SHALL abandon the frame; the first enabled cycle after release SHALL start a new frame at slice 0.
REQ-020 rst SHALL take priority over hold.

Configuration
REQ-021 Macro X_IN_TO_N_OUT_PARITY_EN: when defined, adds output port par (1 bit) and internal accumulator acc.
REQ-022 With the macro: acc SHALL XOR-accumulate every slice loaded onto out within a frame; on the cycle out loads the last slice, par SHALL load the XOR of all NUM_INS bits of that frame and acc SHALL clear.
REQ-023 Without the macro: port par, acc and their logic SHALL be absent; all other behaviour identical.

Structure
REQ-024 Package x_in_to_n_out_pkg SHALL hold functions num_slices(NUM_INS, NUM_OUTS) and cnt_width(num_slices), so benches and wrappers compute the same values.
REQ-025 Sub-module wrap_cnt (parameter MAX, inputs clk/rst/en, outputs cnt and last) SHALL implement the wrapping counter; x_in_to_n_out SHALL instantiate it once.

Verification
REQ-026 NUM_INS=8, NUM_OUTS=1, in=8'hA5 held constant -> out sequence 1,0,1,0,0,1,0,1 repeating; sof high every 8th cycle, aligned with bit 0.
REQ-027 NUM_INS=10, NUM_OUTS=4, in=10'h3FF -> out 4'hF, 4'hF, 4'h3 repeating every 3 cycles; cnt never reaches 3.
REQ-028 NUM_INS=8, NUM_OUTS=2, in=8'h1B sampled at sof cycle, then in=8'hFF -> frame still outputs 2'h3, 2'h2, 2'h1, 2'h0; next frame outputs 2'h3 x4.
REQ-029 hold high 5 cycles after slice 2 -> out and sof unchanged for 5 cycles, slice 3 follows on release; rst pulse at slice 2 -> out=0, sof=0 immediately, next enabled cycle gives slice 0 with sof=1.
REQ-030 PARITY_EN, NUM_INS=8, NUM_OUTS=2, in=8'h07 -> par=1 after last slice of frame; in=8'h03 -> par=0 after next frame.
